pot_scanner: RTL and testbench

POT_SCANNER -- requirements
Module: pot_scanner

---
 rtl/pot_scanner.sv | 204 ++++++++++++++++++++
 tb/tb_pot_scanner.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pot_scanner.sv
// Round-robin scanner for twelve potentiometers on two 8-channel SPI ADCs.
// Each slot runs one 17-period conversion frame; results pass a hysteresis filter.
module pot_scanner #(
    parameter int DCLK_DIV = 25,
    parameter int CS_GAP   = 50,
    parameter int HYST     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cipo,
    output logic       copi,
    output logic       dclk,
    output logic       cs0,
    output logic       cs1,
    output logic [9:0] volume,
    output logic [9:0] pitch,
    output logic [9:0] delay_wet,
    output logic [9:0] delay_rate,
    output logic [9:0] delay_feedback,
    output logic [9:0] reverb_wet,
    output logic [9:0] reverb_size,
    output logic [9:0] reverb_feedback,
    output logic [9:0] filter_quality,
    output logic [9:0] filter_cutoff,
    output logic [9:0] distortion_drive,
    output logic [9:0] crush_pressure,
    output logic       scan_done
);

    typedef enum logic [1:0] {
        GAP    = 2'd0,
        FRAME  = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [7:0]  GAP_LAST    = 8'(CS_GAP - 1);
    localparam logic [7:0]  DIV_LAST    = 8'(DCLK_DIV - 1);
    localparam logic [4:0]  LAST_PERIOD = 5'd17;
    localparam logic [4:0]  FIRST_DATA  = 5'd8;
    localparam logic [3:0]  LAST_SLOT   = 4'd11;
    localparam logic [10:0] HYST_LSB    = 11'(HYST);

    state_t      state_q, state_d;
    logic [7:0]  gap_q, gap_d;
    logic [7:0]  cyc_q, cyc_d;
    logic        half_q, half_d;
    logic [4:0]  period_q, period_d;
    logic [3:0]  slot_q, slot_d;
    logic [9:0]  shift_q, shift_d;
    logic [9:0]  pot_q [12];

    logic        cs0_q, cs0_d;
    logic        cs1_q, cs1_d;
    logic        dclk_q, dclk_d;
    logic        copi_q, copi_d;
    logic        done_q, done_d;

    logic        sample;
    logic [9:0]  old_val;
    logic [10:0] diff;
    logic        update;

    // NOTE: every signal driven here gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        gap_d    = gap_q;
        cyc_d    = cyc_q;
        half_d   = half_q;
        period_d = period_q;
        slot_d   = slot_q;

        case (state_q)
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d  = FRAME;
                    gap_d    = '0;
                    cyc_d    = '0;
                    half_d   = 1'b0;
                    period_d = 5'd1;
                end else begin
                    gap_d = gap_q + 8'd1;
                end
            end
            FRAME: begin
                if (cyc_q == DIV_LAST) begin
                    cyc_d = '0;
                    if (!half_q) begin
                        half_d = 1'b1;
                    end else if (period_q == LAST_PERIOD) begin
                        state_d = COMMIT;
                        half_d  = 1'b0;
                    end else begin
                        half_d   = 1'b0;
                        period_d = period_q + 5'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 8'd1;
                end
            end
            COMMIT: begin
                state_d = GAP;
                slot_d  = (slot_q == LAST_SLOT) ? 4'd0 : slot_q + 4'd1;
            end
            default: state_d = GAP;
        endcase
    end

    // cipo is taken in the first high cycle of each dclk period.
    always_comb begin
        sample  = (state_q == FRAME) && half_q && (cyc_q == 8'd0);
        shift_d = shift_q;
        if (sample && (period_q >= FIRST_DATA)) begin
            shift_d = {shift_q[8:0], cipo};
        end
    end

    // Pins are registered from next-state values so they line up with the FSM.
    always_comb begin
        cs0_d  = !((state_d == FRAME) && !slot_d[3]);
        cs1_d  = !((state_d == FRAME) && slot_d[3]);
        dclk_d = (state_d == FRAME) && half_d;
        done_d = (state_d == COMMIT) && (slot_d == LAST_SLOT);
        copi_d = 1'b0;
        if (state_d == FRAME) begin
            case (period_d)
                5'd1, 5'd2: copi_d = 1'b1;
                5'd3:       copi_d = slot_d[2];
                5'd4:       copi_d = slot_d[1];
                5'd5:       copi_d = slot_d[0];
                default:    copi_d = 1'b0;
            endcase
        end
    end

    // Dead-band filter; endpoints always pass so full travel is reachable.
    always_comb begin
        old_val = pot_q[slot_q];
        if (shift_q > old_val) begin
            diff = {1'b0, shift_q} - {1'b0, old_val};
        end else begin
            diff = {1'b0, old_val} - {1'b0, shift_q};
        end
        update = (diff > HYST_LSB) || (shift_q == 10'd0) || (shift_q == 10'h3FF);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= GAP;
            gap_q    <= '0;
            cyc_q    <= '0;
            half_q   <= 1'b0;
            period_q <= '0;
            slot_q   <= '0;
            shift_q  <= '0;
            cs0_q    <= 1'b1;
            cs1_q    <= 1'b1;
            dclk_q   <= 1'b0;
            copi_q   <= 1'b0;
            done_q   <= 1'b0;
            // NOTE: the value store is reset element by element because these
            // registers drive outputs that must read zero during reset.
            for (int i = 0; i < 12; i++) begin
                pot_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            gap_q    <= gap_d;
            cyc_q    <= cyc_d;
            half_q   <= half_d;
            period_q <= period_d;
            slot_q   <= slot_d;
            shift_q  <= shift_d;
            cs0_q    <= cs0_d;
            cs1_q    <= cs1_d;
            dclk_q   <= dclk_d;
            copi_q   <= copi_d;
            done_q   <= done_d;
            if ((state_q == COMMIT) && update) begin
                pot_q[slot_q] <= shift_q;
            end
        end
    end

    assign cs0       = cs0_q;
    assign cs1       = cs1_q;
    assign dclk      = dclk_q;
    assign copi      = copi_q;
    assign scan_done = done_q;

    assign volume           = pot_q[0];
    assign pitch            = pot_q[1];
    assign delay_wet        = pot_q[2];
    assign delay_rate       = pot_q[3];
    assign delay_feedback   = pot_q[4];
    assign reverb_wet       = pot_q[5];
    assign reverb_size      = pot_q[6];
    assign reverb_feedback  = pot_q[7];
    assign filter_quality   = pot_q[8];
    assign filter_cutoff    = pot_q[9];
    assign distortion_drive = pot_q[10];
    assign crush_pressure   = pot_q[11];

endmodule

// File: tb/tb_pot_scanner.sv
// Bench for pot_scanner: an ADC model answers on cipo, a scoreboard applies the
// dead-band rule per completed frame, and directed plus random scans are compared.
module tb_pot_scanner;

    localparam int DIV      = 2;
    localparam int GAPC     = 3;
    localparam int HYS      = 2;
    localparam int SLOT_CYC = 34 * DIV + GAPC + 1;
    localparam int SCAN_CYC = 12 * SLOT_CYC;

    logic clk, rst, cipo, copi, dclk, cs0, cs1, scan_done;
    logic [9:0] volume, pitch, delay_wet, delay_rate, delay_feedback, reverb_wet;
    logic [9:0] reverb_size, reverb_feedback, filter_quality, filter_cutoff;
    logic [9:0] distortion_drive, crush_pressure;

    pot_scanner #(.DCLK_DIV(DIV), .CS_GAP(GAPC), .HYST(HYS)) dut (
        .clk(clk), .rst(rst), .cipo(cipo), .copi(copi), .dclk(dclk),
        .cs0(cs0), .cs1(cs1),
        .volume(volume), .pitch(pitch), .delay_wet(delay_wet),
        .delay_rate(delay_rate), .delay_feedback(delay_feedback),
        .reverb_wet(reverb_wet), .reverb_size(reverb_size),
        .reverb_feedback(reverb_feedback), .filter_quality(filter_quality),
        .filter_cutoff(filter_cutoff), .distortion_drive(distortion_drive),
        .crush_pressure(crush_pressure), .scan_done(scan_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- ADC model and scoreboard ----------------
    int adc_mem [16];
    int model [12];
    int frame_q [$];
    int sd_cyc [$];
    int cycle = 0;
    int proto_err = 0;
    int period = 0;
    int chip = 0;
    int cur_slot = -1;
    int cur_word = 0;
    int rises = 0;
    int cs0_low = 0;
    int cs1_low = 0;
    int copi_at [18];
    int p3_bits = 0, p3_rises = 0, p3_cs0_low = 0, p3_cs1_low = 0;

    function automatic int hyst_rule(input int old, input int nw);
        int d;
        d = (nw > old) ? nw - old : old - nw;
        return (d > HYS || nw == 0 || nw == 1023) ? nw : old;
    endfunction

    function automatic int pot_out(input int i);
        case (i)
            0:  return int'(volume);
            1:  return int'(pitch);
            2:  return int'(delay_wet);
            3:  return int'(delay_rate);
            4:  return int'(delay_feedback);
            5:  return int'(reverb_wet);
            6:  return int'(reverb_size);
            7:  return int'(reverb_feedback);
            8:  return int'(filter_quality);
            9:  return int'(filter_cutoff);
            10: return int'(distortion_drive);
            default: return int'(crush_pressure);
        endcase
    endfunction

    initial begin
        logic p_cs0, p_cs1, p_dclk, p_copi;
        logic in_f, was_f, cs_fell, cs_rose, dclk_fell, dclk_rose;
        p_cs0 = 1'b1; p_cs1 = 1'b1; p_dclk = 1'b0; p_copi = 1'b0;
        cipo = 1'b0;
        forever begin
            @(negedge clk);
            cycle++;
            if (!rst) begin
                for (int i = 0; i < 12; i++) model[i] = 0;
            end
            in_f      = !cs0 || !cs1;
            was_f     = !p_cs0 || !p_cs1;
            cs_fell   = in_f && !was_f;
            cs_rose   = !in_f && was_f;
            dclk_fell = p_dclk && !dclk;
            dclk_rose = !p_dclk && dclk;
            if (rst) begin
                if (!cs0 && !cs1) proto_err++;
                if (dclk && !in_f) proto_err++;
                if (copi != p_copi && !cs_fell && !dclk_fell) proto_err++;
            end
            if (cs_fell) begin
                period = 1; chip = cs0 ? 1 : 0; rises = 0;
                cs0_low = 0; cs1_low = 0; cur_slot = -1;
            end else if (in_f && dclk_fell) begin
                period++;
            end
            if (in_f) begin
                if (!cs0) cs0_low++;
                if (!cs1) cs1_low++;
            end
            if (in_f && dclk_rose) begin
                rises++;
                if (period < 18) copi_at[period] = int'(copi);
                if (period == 5) begin
                    cur_slot = chip * 8 + copi_at[3] * 4 + copi_at[4] * 2 + copi_at[5];
                    cur_word = adc_mem[cur_slot];
                end
            end
            if (cs_rose && rst && cur_slot >= 0) begin
                frame_q.push_back(cur_slot);
                if (cur_slot < 12) model[cur_slot] = hyst_rule(model[cur_slot], cur_word);
                if (cur_slot == 3) begin
                    p3_bits = copi_at[1] * 16 + copi_at[2] * 8 + copi_at[3] * 4
                            + copi_at[4] * 2 + copi_at[5];
                    p3_rises = rises; p3_cs0_low = cs0_low; p3_cs1_low = cs1_low;
                end
            end
            if (!in_f) period = 0;
            cipo = (in_f && period >= 8 && period <= 17) ? 1'((cur_word >> (17 - period)) & 1) : 1'b0;
            if (scan_done && rst) sd_cyc.push_back(cycle);
            p_cs0 = cs0; p_cs1 = cs1; p_dclk = dclk; p_copi = copi;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic release_rst(output int n);
        @(posedge clk);
        #2 rst = 1'b1;
        n = 0;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk); #1;
            n++;
            if (!cs0 || !cs1) break;
        end
    endtask

    task automatic run_scan();
        int target;
        target = sd_cyc.size() + 1;
        for (int i = 0; i < 2 * SCAN_CYC + 100; i++) begin
            @(posedge clk);
            if (sd_cyc.size() >= target) break;
        end
        check("scan_wait", int'(sd_cyc.size() >= target), 1);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        for (int s = 0; s < 12; s++) begin
            check($sformatf("%s_pot%0d", tag, s), pot_out(s), model[s]);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int n, base, sd_base, r, v;
        int vol_seq [5]   = '{500, 502, 503, 1, 0};
        int vol_exp [5]   = '{500, 500, 503, 1, 0};

        rst = 1'b0;
        for (int i = 0; i < 16; i++) adc_mem[i] = 64 * (i % 8) + 5;

        repeat (3) @(posedge clk);
        #1;
        check("rst_cs0", int'(cs0), 1);
        check("rst_cs1", int'(cs1), 1);
        check("rst_dclk", int'(dclk), 0);
        check("rst_copi", int'(copi), 0);
        check("rst_scan_done", int'(scan_done), 0);
        check("rst_volume", int'(volume), 0);
        check("rst_crush", int'(crush_pressure), 0);

        release_rst(n);
        check("gap_after_reset", n, GAPC);

        run_scan();
        check("first_frame_slot", (frame_q.size() > 0) ? frame_q[0] : -1, 0);
        check("scan1_volume", int'(volume), 5);
        check("scan1_reverb_fb", int'(reverb_feedback), 453);
        check("scan1_filter_q", int'(filter_quality), 5);
        check("scan1_crush", int'(crush_pressure), 197);
        check("scan1_done_pulses", sd_cyc.size(), 1);
        check_all("scan1");
        check("slot3_copi_hdr", p3_bits, 5'b11011);
        check("slot3_dclk_rises", p3_rises, 17);
        check("slot3_cs0_low", p3_cs0_low, 34 * DIV);
        check("slot3_cs1_low", p3_cs1_low, 0);

        for (int k = 0; k < 5; k++) begin
            adc_mem[0] = vol_seq[k];
            if (k == 0) adc_mem[1] = 1022;
            if (k == 1) adc_mem[1] = 1023;
            run_scan();
            check($sformatf("hyst_volume_%0d", k), int'(volume), vol_exp[k]);
            if (k == 0) check("pitch_1022", int'(pitch), 1022);
            if (k == 1) check("pitch_endpoint", int'(pitch), 1023);
        end

        for (int sc = 0; sc < 3; sc++) begin
            for (int s = 0; s < 12; s++) begin
                r = int'($urandom_range(0, 3));
                case (r)
                    0: v = int'($urandom_range(0, 1023));
                    1: v = model[s] + int'($urandom_range(0, 8)) - 4;
                    2: v = (s % 2 == 0) ? 0 : 1023;
                    default: v = model[s] + int'($urandom_range(0, 2));
                endcase
                if (v < 0) v = 0;
                if (v > 1023) v = 1023;
                adc_mem[s < 8 ? s : s] = v;
            end
            run_scan();
            check_all($sformatf("rand%0d", sc));
        end
        check("protocol_errors", proto_err, 0);

        adc_mem[5] = 777;
        for (int i = 0; i < 2 * SCAN_CYC; i++) begin
            @(posedge clk); #1;
            if (cur_slot == 5 && period == 10) break;
        end
        check("abort_reached", int'(cur_slot == 5 && period == 10), 1);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("abort_cs0", int'(cs0), 1);
        check("abort_dclk", int'(dclk), 0);
        check("abort_reverb_wet", int'(reverb_wet), 0);
        base = frame_q.size();
        sd_base = sd_cyc.size();
        release_rst(n);
        check("gap_after_abort", n, GAPC);

        for (int i = 0; i < 27 * SLOT_CYC; i++) begin
            @(posedge clk);
            if (frame_q.size() >= base + 25) break;
        end
        repeat (2) @(posedge clk);
        #1;
        check("wrap_frames", int'(frame_q.size() >= base + 25), 1);
        if (frame_q.size() >= base + 25) begin
            check("post_abort_slot0", frame_q[base], 0);
            check("wrap_slot11", frame_q[base + 11], 11);
            check("wrap_slot0_after_11", frame_q[base + 12], 0);
            check("wrap_slot0_second", frame_q[base + 24], 0);
        end
        check("wrap_done_pulses", sd_cyc.size() - sd_base, 2);
        if (sd_cyc.size() - sd_base == 2) begin
            check("wrap_done_spacing", sd_cyc[sd_base + 1] - sd_cyc[sd_base], SCAN_CYC);
        end
        check("wrap_reverb_wet", int'(reverb_wet), 777);
        check_all("wrap");
        check("protocol_errors_end", proto_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
